// File: rtl/uart_transmitter.sv
// UART transmit path: 11-bit frames (start, 8 data LSB-first, even parity, stop)
// paced by a 16x oversampling tick from baud_controller.
module uart_transmitter (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  output logic       TxD,
  output logic       Tx_BUSY,
  output logic       Tx_DONE
);

  typedef enum logic [2:0] {StIdle, StWait, StStart, StData, StParity, StStop} state_e;

  state_e     state_q;
  logic [7:0] shift_q;
  logic       parity_q;
  logic [2:0] bit_cnt_q;
  logic [3:0] tick_cnt_q;
  logic       Tx_sample_ENABLE;
  logic       last_tick;
  logic       in_frame;

  baud_controller u_baud (
    .reset        (reset),
    .clk          (clk),
    .baud_select  (baud_select),
    .sample_enable(Tx_sample_ENABLE)
  );

  assign last_tick = Tx_sample_ENABLE && (tick_cnt_q == 4'd15);
  assign in_frame  = (state_q == StStart) || (state_q == StData) ||
                     (state_q == StParity) || (state_q == StStop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      shift_q    <= 8'h00;
      parity_q   <= 1'b0;
      bit_cnt_q  <= 3'd0;
      tick_cnt_q <= 4'd0;
      TxD        <= 1'b1;
      Tx_BUSY    <= 1'b0;
      Tx_DONE    <= 1'b0;
    end else begin
      Tx_DONE <= 1'b0;
      if ((state_q != StIdle) && !Tx_EN) begin
        // Losing the enable mid-frame drops the word and returns the line to idle.
        state_q    <= StIdle;
        shift_q    <= 8'h00;
        bit_cnt_q  <= 3'd0;
        tick_cnt_q <= 4'd0;
        TxD        <= 1'b1;
        Tx_BUSY    <= 1'b0;
      end else begin
        if (in_frame && Tx_sample_ENABLE) begin
          tick_cnt_q <= tick_cnt_q + 4'd1;
        end
        unique case (state_q)
          StIdle: begin
            if (Tx_WR && Tx_EN) begin
              shift_q    <= Tx_DATA;
              parity_q   <= ^Tx_DATA;
              bit_cnt_q  <= 3'd0;
              tick_cnt_q <= 4'd0;
              Tx_BUSY    <= 1'b1;
              state_q    <= StWait;
            end
          end
          StWait: begin
            // Start bit aligns to the tick grid so every bit is exactly 16 ticks.
            if (Tx_sample_ENABLE) begin
              TxD     <= 1'b0;
              state_q <= StStart;
            end
          end
          StStart: begin
            if (last_tick) begin
              TxD     <= shift_q[0];
              state_q <= StData;
            end
          end
          StData: begin
            if (last_tick) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                TxD     <= parity_q;
                state_q <= StParity;
              end else begin
                shift_q <= {1'b0, shift_q[7:1]};
                TxD     <= shift_q[1];
              end
            end
          end
          StParity: begin
            if (last_tick) begin
              TxD     <= 1'b1;
              state_q <= StStop;
            end
          end
          StStop: begin
            if (last_tick) begin
              Tx_BUSY <= 1'b0;
              Tx_DONE <= 1'b1;
              state_q <= StIdle;
            end
          end
          default: begin
            TxD     <= 1'b1;
            Tx_BUSY <= 1'b0;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// Free-running 16x baud tick: one-cycle pulse every N clk cycles (50 MHz clock).
module baud_controller (
  input  logic       reset,
  input  logic       clk,
  input  logic [2:0] baud_select,
  output logic       sample_enable
);

  logic [13:0] divisor;
  logic [13:0] count_q;

  always_comb begin
    divisor = 14'd27;
    unique case (baud_select)
      3'b000:  divisor = 14'd10417;
      3'b001:  divisor = 14'd2604;
      3'b010:  divisor = 14'd651;
      3'b011:  divisor = 14'd326;
      3'b100:  divisor = 14'd163;
      3'b101:  divisor = 14'd81;
      3'b110:  divisor = 14'd54;
      3'b111:  divisor = 14'd27;
      default: divisor = 14'd27;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q       <= 14'd0;
      sample_enable <= 1'b0;
    end else if (count_q >= divisor - 14'd1) begin
      // >= keeps the counter bounded if the rate code drops to a shorter period.
      count_q       <= 14'd0;
      sample_enable <= 1'b1;
    end else begin
      count_q       <= count_q + 14'd1;
      sample_enable <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Randomised self-checking bench for uart_transmitter against a frame-level line model.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] baud_select;
  logic       Tx_EN;
  logic       Tx_WR;
  logic [7:0] Tx_DATA;
  logic       TxD;
  logic       Tx_BUSY;
  logic       Tx_DONE;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  uart_transmitter dut (
    .clk        (clk),
    .reset      (reset),
    .baud_select(baud_select),
    .Tx_EN      (Tx_EN),
    .Tx_WR      (Tx_WR),
    .Tx_DATA    (Tx_DATA),
    .TxD        (TxD),
    .Tx_BUSY    (Tx_BUSY),
    .Tx_DONE    (Tx_DONE)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int divisor(input logic [2:0] sel);
    case (sel)
      3'b000:  return 10417;
      3'b001:  return 2604;
      3'b010:  return 651;
      3'b011:  return 326;
      3'b100:  return 163;
      3'b101:  return 81;
      3'b110:  return 54;
      default: return 27;
    endcase
  endfunction

  task automatic write_word(input logic [7:0] data);
    Tx_WR   = 1'b1;
    Tx_DATA = data;
    @(negedge clk);
    Tx_WR   = 1'b0;
  endtask

  task automatic idle_watch(input int cycles, input string tag);
    int bad = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (TxD !== 1'b1 || Tx_BUSY !== 1'b0 || Tx_DONE !== 1'b0) bad++;
    end
    check({tag, " idle"}, bad, 0);
  endtask

  // Writes one word and checks the first nbits frame bits cycle by cycle. With nbits == 11
  // it also checks the done edge and returns on the cycle Tx_DONE is high; otherwise it
  // returns on the first cycle of frame bit nbits. A one-cycle write of spur_data is
  // injected spur_k cycles after the start edge (negative = none).
  task automatic send_frame(input logic [7:0] data, input int nbits, input int spur_k,
                            input logic [7:0] spur_data, input string tag);
    int          n;
    int          bit_len;
    int          lat;
    int          done_errs;
    int          busy_errs;
    int          errs [11];
    logic [10:0] frame;
    logic [10:0] mid;
    n       = divisor(baud_select);
    bit_len = 16 * n;
    frame[0] = 1'b0;
    for (int i = 0; i < 8; i++) frame[i + 1] = data[i];
    frame[9]  = (($countones(data) % 2) == 1);
    frame[10] = 1'b1;

    write_word(data);
    check({tag, " busy_rise"}, Tx_BUSY, 1);
    check({tag, " done_low"}, Tx_DONE, 0);
    lat = 0;
    while (TxD === 1'b1 && lat <= n + 1) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " start_seen"}, TxD, 0);
    if (TxD !== 1'b0) return;
    check({tag, " start_latency"}, (lat >= 1 && lat <= n), 1);

    for (int b = 0; b < 11; b++) errs[b] = 0;
    done_errs = 0;
    busy_errs = 0;
    mid       = '1;
    for (int k = 0; k < nbits * bit_len; k++) begin
      int b;
      b = k / bit_len;
      if (TxD !== frame[b]) errs[b]++;
      if (Tx_DONE !== 1'b0) done_errs++;
      if (Tx_BUSY !== 1'b1) busy_errs++;
      if (k == b * bit_len + bit_len / 2) mid[b] = TxD;
      if (k == spur_k) begin
        Tx_WR   = 1'b1;
        Tx_DATA = spur_data;
      end else begin
        Tx_WR = 1'b0;
      end
      @(negedge clk);
    end
    Tx_WR = 1'b0;

    for (int b = 0; b < nbits; b++) check($sformatf("%s bit%0d", tag, b), errs[b], 0);
    check({tag, " no_early_done"}, done_errs, 0);
    check({tag, " busy_held"}, busy_errs, 0);
    if (nbits == 11) begin
      check({tag, " done_pulse"}, Tx_DONE, 1);
      check({tag, " busy_fall"}, Tx_BUSY, 0);
      check({tag, " line_idle"}, TxD, 1);
      check({tag, " rx_data"}, mid[8:1], data);
      check({tag, " rx_parity_even"}, ^mid[9:1], 0);
      check({tag, " rx_stop"}, mid[10], 1);
    end
  endtask

  initial begin
    #(20 * 120000);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rdata;
    int         n;
    reset       = 1'b1;
    Tx_EN       = 1'b0;
    Tx_WR       = 1'b0;
    Tx_DATA     = 8'h00;
    baud_select = 3'b111;
    repeat (3) @(negedge clk);
    check("reset TxD", TxD, 1);
    check("reset busy", Tx_BUSY, 0);
    check("reset done", Tx_DONE, 0);
    reset = 1'b0;
    Tx_EN = 1'b1;
    @(negedge clk);
    n = divisor(baud_select);

    send_frame(8'h55, 11, -1, 8'h00, "w55");
    @(negedge clk);
    check("w55 done_one_cycle", Tx_DONE, 0);

    send_frame(8'h01, 11, -1, 8'h00, "w01");
    send_frame(8'hFF, 11, -1, 8'h00, "wFF");
    // Writes during DATA and on the STOP completion edge must both be dropped.
    send_frame(8'hA3, 11, 16 * n * 3 + 7, 8'h3C, "wA3");
    send_frame(8'h5A, 11, 176 * n - 1, 8'h99, "w5A");
    send_frame(8'hC4, 11, -1, 8'h00, "wC4");
    @(negedge clk);

    send_frame(8'h0F, 4, -1, 8'h00, "abort_en");
    repeat (5) @(negedge clk);
    Tx_EN = 1'b0;
    @(negedge clk);
    check("abort_en TxD", TxD, 1);
    check("abort_en busy", Tx_BUSY, 0);
    check("abort_en done", Tx_DONE, 0);
    idle_watch(32 * n, "abort_en");
    write_word(8'h77);
    check("wr_disabled busy", Tx_BUSY, 0);
    idle_watch(2 * n, "wr_disabled");
    Tx_EN = 1'b1;
    @(negedge clk);

    rdata = 8'($urandom);
    send_frame(rdata, 9, -1, 8'h00, "reset_par");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_par TxD", TxD, 1);
    check("reset_par busy", Tx_BUSY, 0);
    check("reset_par done", Tx_DONE, 0);
    reset = 1'b0;
    @(negedge clk);
    send_frame(8'h81, 11, -1, 8'h00, "w81");

    for (int r = 0; r < 2; r++) begin
      send_frame(8'($urandom), 11, $urandom_range(16 * n, 16 * n * 10), 8'($urandom),
                 $sformatf("rand%0d", r));
    end
    @(negedge clk);

    baud_select = 3'b011;
    @(negedge clk);
    send_frame(8'hC4, 4, -1, 8'h00, "b9600");
    Tx_EN = 1'b0;
    @(negedge clk);
    check("b9600 abort busy", Tx_BUSY, 0);
    Tx_EN       = 1'b1;
    baud_select = 3'b111;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
